fetch_stage: RTL and testbench

Instruction fetch stage with PC register, single-entry skid buffer and IF/ID pipeline register. It issues word fetches to instruction memory and holds the fetched instruction for decode. It presents the 16-bit immediate plus a decoded extension select that drive the `extender` directly in ID.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_ext_sel_decode.sv | 18 +
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared opcode, extender-select and IF/ID entry definitions
package fetch_stage_pkg;

    localparam logic [1:0] EXT_SEL_SIGN = 2'b00;
    localparam logic [1:0] EXT_SEL_ZERO = 2'b01;
    localparam logic [1:0] EXT_SEL_LUI  = 2'b10;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_ext_sel_decode.sv
// rtl/fetch_stage_ext_sel_decode.sv - opcode to extender select; shared with the control unit
module ext_sel_decode
    import fetch_stage_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] ext_sel
);

    always_comb begin
        ext_sel = EXT_SEL_SIGN;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: ext_sel = EXT_SEL_ZERO;
            OP_LUI:                   ext_sel = EXT_SEL_LUI;
            default:                  ext_sel = EXT_SEL_SIGN;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, single-entry skid buffer and IF/ID pipeline register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [15:0] id_imm16,
    output logic [1:0]  id_ext_sel
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    ifid_t       skid;
    ifid_t       ifid;

    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc;
    assign id_pc     = ifid.pc;
    assign id_instr  = ifid.instr;
    assign id_imm16  = ifid.instr[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            ifid     <= '0;
            skid     <= '0;
        end else if (redirect_valid) begin
            // Redirect abandons any returned word and the buffered one alike.
            state    <= S_FETCH;
            pc       <= redirect_pc & 32'hFFFF_FFFC;
            id_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        pc <= pc + 32'd4;
                        if (stall) begin
                            skid.pc    <= pc;
                            skid.instr <= imem_rdata;
                            state      <= S_HOLD;
                        end else begin
                            ifid.pc    <= pc;
                            ifid.instr <= imem_rdata;
                            id_valid   <= 1'b1;
                        end
                    end else if (!stall) begin
                        id_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid     <= skid;
                        id_valid <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    ext_sel_decode u_ext_sel_decode (
        .opcode  (ifid.instr[31:26]),
        .ext_sel (id_ext_sel)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [15:0] id_imm16;
    logic [1:0]  id_ext_sel;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_imm16       (id_imm16),
        .id_ext_sel     (id_ext_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] sel);
        case (sel)
            EXT_SEL_ZERO: extend = {16'h0000, imm};
            EXT_SEL_LUI:  extend = {imm, 16'h0000};
            default:      extend = {{16{imm[15]}}, imm};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        check("rst_req",    {31'd0, imem_req}, 32'd0);
        check("rst_addr",   imem_addr, 32'h0000_3000);
        check("rst_valid",  {31'd0, id_valid}, 32'd0);
        check("rst_pc",     id_pc, 32'd0);
        check("rst_instr",  id_instr, 32'd0);
        check("rst_imm",    {16'd0, id_imm16}, 32'd0);
        check("rst_extsel", {30'd0, id_ext_sel}, {30'd0, EXT_SEL_SIGN});
        rst = 1'b0;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);

        // lui streaming at full throughput
        imem_ready = 1'b1; imem_rdata = 32'h3C01_F234;
        step();
        check("lui_valid", {31'd0, id_valid}, 32'd1);
        check("lui_pc0",   id_pc, 32'h0000_3000);
        check("addr_3004", imem_addr, 32'h0000_3004);
        step();
        check("lui_pc1",   id_pc, 32'h0000_3004);
        check("addr_3008", imem_addr, 32'h0000_3008);
        check("lui_instr", id_instr, 32'h3C01_F234);
        check("lui_imm",   {16'd0, id_imm16}, 32'h0000_F234);
        check("lui_sel",   {30'd0, id_ext_sel}, {30'd0, EXT_SEL_LUI});
        check("lui_ext",   extend(id_imm16, id_ext_sel), 32'hF234_0000);

        imem_rdata = 32'h3421_F234;
        step();
        check("ori_sel", {30'd0, id_ext_sel}, {30'd0, EXT_SEL_ZERO});
        check("ori_ext", extend(id_imm16, id_ext_sel), 32'h0000_F234);
        check("ori_pc",  id_pc, 32'h0000_3008);
        imem_rdata = 32'h2021_F234;
        step();
        check("addi_sel", {30'd0, id_ext_sel}, {30'd0, EXT_SEL_SIGN});
        check("addi_ext", extend(id_imm16, id_ext_sel), 32'hFFFF_F234);
        check("addi_pc",  id_pc, 32'h0000_300C);

        // bubble when memory is not ready
        imem_ready = 1'b0;
        step();
        check("bubble_valid", {31'd0, id_valid}, 32'd0);
        check("bubble_addr",  imem_addr, 32'h0000_3010);

        // stall three cycles with memory ready
        imem_ready = 1'b1; imem_rdata = 32'hAAAA_0001;
        step();
        check("pre_stall_pc", id_pc, 32'h0000_3010);
        stall = 1'b1; imem_rdata = 32'hBBBB_0002;
        step();
        check("hold_req",   {31'd0, imem_req}, 32'd0);
        check("hold_instr", id_instr, 32'hAAAA_0001);
        check("hold_addr",  imem_addr, 32'h0000_3018);
        imem_rdata = 32'hCCCC_0003;
        step();
        step();
        check("hold3_req",   {31'd0, imem_req}, 32'd0);
        check("hold3_pc",    id_pc, 32'h0000_3010);
        check("hold3_instr", id_instr, 32'hAAAA_0001);
        check("hold3_valid", {31'd0, id_valid}, 32'd1);
        stall = 1'b0; imem_rdata = 32'hDDDD_0004;
        step();
        check("release_instr", id_instr, 32'hBBBB_0002);
        check("release_pc",    id_pc, 32'h0000_3014);
        check("release_req",   {31'd0, imem_req}, 32'd1);
        check("release_addr",  imem_addr, 32'h0000_3018);
        step();
        check("after_instr", id_instr, 32'hDDDD_0004);
        check("after_pc",    id_pc, 32'h0000_3018);

        // redirect with same-cycle ready and stall
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4007; stall = 1'b1;
        imem_rdata = 32'hEEEE_0005;
        step();
        check("redir_valid", {31'd0, id_valid}, 32'd0);
        check("redir_addr",  imem_addr, 32'h0000_4004);
        check("redir_req",   {31'd0, imem_req}, 32'd1);
        redirect_valid = 1'b0; stall = 1'b0; imem_rdata = 32'h1111_0006;
        step();
        check("redir_id_pc",    id_pc, 32'h0000_4004);
        check("redir_id_instr", id_instr, 32'h1111_0006);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ready = 1'b0;
        step();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h4444_0009;
        step();
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

        // asynchronous reset while holding a buffered word
        stall = 1'b1; imem_rdata = 32'h2222_0007;
        step();
        check("pre_rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, id_valid}, 32'd0);
        check("arst_addr",  imem_addr, 32'h0000_3000);
        check("arst_req",   {31'd0, imem_req}, 32'd0);
        stall = 1'b0; imem_ready = 1'b0;
        step();
        rst = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h3333_0008;
        step();
        check("post_rst_instr", id_instr, 32'h3333_0008);
        check("post_rst_pc",    id_pc, 32'h0000_3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
